dcache_refill_unit: RTL and testbench

- Sits directly upstream of the 128-set × 8-word × 32-bit two-port data SRAM array and is its only write master.
- Collects an 8-beat critical-word-first refill burst from the memory side into a line buffer, then commits the whole line in one SRAM write cycle.
- In parallel, forwards single-word store writes to the array.
- A store that targets the set being refilled is merged into the line buffer, so the refill cannot overwrite it.

---
 rtl/dcache_refill_unit_if.sv | 68 ++++++
 rtl/dcache_refill_unit.sv | 180 ++++++++++++++++++
 tb/tb_dcache_refill_unit.sv | 487 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_refill_unit_if.sv
// Signal bundle between the refill unit, the memory-side beat source, the
// store pipeline and the data SRAM write port. The slave side is the refill
// unit; the master side is whoever drives requests, beats and stores.
interface dcache_refill_unit_if #(
   parameter int SET_W  = 7,
   parameter int WORD_W = 3,
   parameter int XLEN   = 32
);

   logic                     io_req_valid;
   logic                     io_req_ready;
   logic [SET_W-1:0]         io_req_set;
   logic [WORD_W-1:0]        io_req_word;

   logic                     io_beat_valid;
   logic                     io_beat_ready;
   logic [XLEN-1:0]          io_beat_data;
   logic                     io_beat_last;

   logic                     io_st_valid;
   logic                     io_st_ready;
   logic [SET_W-1:0]         io_st_set;
   logic [WORD_W-1:0]        io_st_word;
   logic [XLEN-1:0]          io_st_data;

   logic                     io_w_en;
   logic [SET_W-1:0]         io_w_addr;
   logic [XLEN-1:0]          io_w_data_0;
   logic [XLEN-1:0]          io_w_data_1;
   logic [XLEN-1:0]          io_w_data_2;
   logic [XLEN-1:0]          io_w_data_3;
   logic [XLEN-1:0]          io_w_data_4;
   logic [XLEN-1:0]          io_w_data_5;
   logic [XLEN-1:0]          io_w_data_6;
   logic [XLEN-1:0]          io_w_data_7;
   logic [(1<<WORD_W)-1:0]   io_w_maskOH;

   logic                     io_busy;
   logic                     io_done;
   logic                     io_err;

   modport master (
      output io_req_valid, io_req_set, io_req_word,
      input  io_req_ready,
      output io_beat_valid, io_beat_data, io_beat_last,
      input  io_beat_ready,
      output io_st_valid, io_st_set, io_st_word, io_st_data,
      input  io_st_ready,
      input  io_w_en, io_w_addr, io_w_maskOH,
      input  io_w_data_0, io_w_data_1, io_w_data_2, io_w_data_3,
      input  io_w_data_4, io_w_data_5, io_w_data_6, io_w_data_7,
      input  io_busy, io_done, io_err
   );

   modport slave (
      input  io_req_valid, io_req_set, io_req_word,
      output io_req_ready,
      input  io_beat_valid, io_beat_data, io_beat_last,
      output io_beat_ready,
      input  io_st_valid, io_st_set, io_st_word, io_st_data,
      output io_st_ready,
      output io_w_en, io_w_addr, io_w_maskOH,
      output io_w_data_0, io_w_data_1, io_w_data_2, io_w_data_3,
      output io_w_data_4, io_w_data_5, io_w_data_6, io_w_data_7,
      output io_busy, io_done, io_err
   );

endinterface

// File: rtl/dcache_refill_unit.sv
// Data-cache refill unit: gathers an 8-beat critical-word-first refill burst
// into a line buffer and commits it to the data SRAM in one write cycle, while
// forwarding single-word stores. Stores hitting the set being refilled are
// folded into the line buffer so the refill never clobbers newer data.
module dcache_refill_unit #(
   parameter int SETS  = 128,
   parameter int WORDS = 8,
   parameter int XLEN  = 32
) (
   input  logic                clock,
   input  logic                reset,
   dcache_refill_unit_if.slave bus
);

   localparam int SET_W  = $clog2(SETS);
   localparam int WORD_W = $clog2(WORDS);
   localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(WORDS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WRITE = 2'd2
   } state_t;

   state_t              state_q;
   state_t              state_d;

   logic [SET_W-1:0]    set_q;
   logic [WORD_W-1:0]   start_q;
   logic [WORD_W-1:0]   cnt_q;
   logic [WORDS-1:0]    merge_q;
   logic [XLEN-1:0]     buf_q [WORDS];
   logic                err_q;
   logic                done_q;

   logic                req_ready;
   logic                beat_ready;
   logic                st_ready;
   logic                req_fire;
   logic                beat_fire;
   logic                st_fire;
   logic                st_merge;
   logic                st_pass;
   logic [WORD_W-1:0]   beat_idx;
   logic                drop_beat;
   logic                beat_last_bad;

   logic                w_en;
   logic [SET_W-1:0]    w_addr;
   logic [WORDS-1:0]    w_mask;
   logic [XLEN-1:0]     w_data [WORDS];

   assign req_ready  = (state_q == IDLE);
   assign beat_ready = (state_q == FILL);
   assign st_ready   = (state_q != WRITE);

   assign req_fire   = bus.io_req_valid  & req_ready;
   assign beat_fire  = bus.io_beat_valid & beat_ready;
   assign st_fire    = bus.io_st_valid   & st_ready;

   // A store to the set being filled is absorbed into the line buffer;
   // every other accepted store goes straight to the array.
   assign st_merge   = st_fire & (state_q == FILL) & (bus.io_st_set == set_q);
   assign st_pass    = st_fire & ~st_merge;

   // Beat k of the burst lands in word (start + k) mod WORDS; the narrow
   // adder provides the wrap for free.
   assign beat_idx   = start_q + cnt_q;

   // A beat loses to any store that already claimed its word or claims it
   // in this same cycle.
   assign drop_beat  = merge_q[beat_idx] | (st_merge & (bus.io_st_word == beat_idx));

   // The source must mark exactly the final beat as last.
   assign beat_last_bad = bus.io_beat_last != (cnt_q == LAST_BEAT);

   // State register; reset abandons any burst in progress.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: the burst length is fixed, so sequencing depends only
   // on the beat count and never on the source's last flag.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_fire) state_d = FILL;
         FILL:    if (beat_fire && (cnt_q == LAST_BEAT)) state_d = WRITE;
         WRITE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Line buffer, merge mask, beat counter and status flags.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         set_q   <= '0;
         start_q <= '0;
         cnt_q   <= '0;
         merge_q <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
         for (int i = 0; i < WORDS; i++) begin
            buf_q[i] <= '0;
         end
      end else begin
         done_q <= (state_q == WRITE);
         if (req_fire) begin
            set_q   <= bus.io_req_set;
            start_q <= bus.io_req_word;
            cnt_q   <= '0;
            merge_q <= '0;
            err_q   <= 1'b0;
         end
         if (beat_fire) begin
            cnt_q <= cnt_q + WORD_W'(1);
            if (!drop_beat) begin
               buf_q[beat_idx] <= bus.io_beat_data;
            end
            if (beat_last_bad) begin
               err_q <= 1'b1;
            end
         end
         if (st_merge) begin
            buf_q[bus.io_st_word]   <= bus.io_st_data;
            merge_q[bus.io_st_word] <= 1'b1;
         end
      end
   end

   // Array write port: the line commit owns it in WRITE (stores are held off
   // there), otherwise a pass-through store drives it in the same cycle.
   always_comb begin
      w_en   = 1'b0;
      w_addr = '0;
      w_mask = '0;
      for (int i = 0; i < WORDS; i++) begin
         w_data[i] = '0;
      end
      if (state_q == WRITE) begin
         w_en   = 1'b1;
         w_addr = set_q;
         w_mask = '1;
         for (int i = 0; i < WORDS; i++) begin
            w_data[i] = buf_q[i];
         end
      end else if (st_pass) begin
         w_en   = 1'b1;
         w_addr = bus.io_st_set;
         w_mask = WORDS'(1) << bus.io_st_word;
         for (int i = 0; i < WORDS; i++) begin
            w_data[i] = bus.io_st_data;
         end
      end
   end

   assign bus.io_req_ready  = req_ready;
   assign bus.io_beat_ready = beat_ready;
   assign bus.io_st_ready   = st_ready;
   assign bus.io_busy       = (state_q != IDLE);
   assign bus.io_done       = done_q;
   assign bus.io_err        = err_q;

   assign bus.io_w_en       = w_en;
   assign bus.io_w_addr     = w_addr;
   assign bus.io_w_maskOH   = w_mask;
   assign bus.io_w_data_0   = w_data[0];
   assign bus.io_w_data_1   = w_data[1];
   assign bus.io_w_data_2   = w_data[2];
   assign bus.io_w_data_3   = w_data[3];
   assign bus.io_w_data_4   = w_data[4];
   assign bus.io_w_data_5   = w_data[5];
   assign bus.io_w_data_6   = w_data[6];
   assign bus.io_w_data_7   = w_data[7];

endmodule

// File: tb/tb_dcache_refill_unit.sv
// Bench for dcache_refill_unit: directed scenarios for each behaviour plus
// randomized bursts checked cycle by cycle against a line-level model.
module tb_dcache_refill_unit;

   localparam int MAXC = 64;

   logic clock = 1'b0;
   logic reset = 1'b0;

   int total = 0;
   int bad   = 0;

   // Scenario description: cycle 0 offers the request, later cycles offer
   // beats and stores as listed.
   logic [6:0]  sc_set;
   logic [2:0]  sc_start;
   int          sc_len;
   logic [31:0] beats     [8];
   logic        last_bits [8];
   logic        beat_on   [MAXC];
   logic        st_on     [MAXC];
   logic [6:0]  st_set_a  [MAXC];
   logic [2:0]  st_word_a [MAXC];
   logic [31:0] st_data_a [MAXC];

   logic        obs_w_en       [MAXC];
   logic [6:0]  obs_addr       [MAXC];
   logic [7:0]  obs_mask       [MAXC];
   logic [31:0] obs_data       [MAXC][8];
   logic        obs_req_ready  [MAXC];
   logic        obs_beat_ready [MAXC];
   logic        obs_st_ready   [MAXC];
   logic        obs_busy       [MAXC];
   logic        obs_done       [MAXC];
   logic        obs_err        [MAXC];

   logic        exp_w_en       [MAXC];
   logic [6:0]  exp_addr       [MAXC];
   logic [7:0]  exp_mask       [MAXC];
   logic [31:0] exp_data       [MAXC][8];
   logic [4:0]  exp_hs         [MAXC];
   logic        exp_err        [MAXC];

   always #5 clock = ~clock;

   dcache_refill_unit_if bus ();

   dcache_refill_unit dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   task automatic idle_inputs();
      bus.io_req_valid  = 1'b0;
      bus.io_req_set    = '0;
      bus.io_req_word   = '0;
      bus.io_beat_valid = 1'b0;
      bus.io_beat_data  = '0;
      bus.io_beat_last  = 1'b0;
      bus.io_st_valid   = 1'b0;
      bus.io_st_set     = '0;
      bus.io_st_word    = '0;
      bus.io_st_data    = '0;
   endtask

   task automatic clear_schedule();
      for (int c = 0; c < MAXC; c++) begin
         beat_on[c]   = 1'b0;
         st_on[c]     = 1'b0;
         st_set_a[c]  = '0;
         st_word_a[c] = '0;
         st_data_a[c] = '0;
      end
      for (int j = 0; j < 8; j++) begin
         beats[j]     = $urandom;
         last_bits[j] = (j == 7);
      end
   endtask

   task automatic dense_setup(input logic [6:0] set, input logic [2:0] start);
      clear_schedule();
      sc_set   = set;
      sc_start = start;
      for (int c = 1; c <= 8; c++) beat_on[c] = 1'b1;
      sc_len = 8;
   endtask

   task automatic add_store(input int c, input logic [6:0] set, input logic [2:0] word,
                            input logic [31:0] data);
      st_on[c]     = 1'b1;
      st_set_a[c]  = set;
      st_word_a[c] = word;
      st_data_a[c] = data;
   endtask

   task automatic sample(input int c);
      obs_w_en[c]       = bus.io_w_en;
      obs_addr[c]       = bus.io_w_addr;
      obs_mask[c]       = bus.io_w_maskOH;
      obs_data[c][0]    = bus.io_w_data_0;
      obs_data[c][1]    = bus.io_w_data_1;
      obs_data[c][2]    = bus.io_w_data_2;
      obs_data[c][3]    = bus.io_w_data_3;
      obs_data[c][4]    = bus.io_w_data_4;
      obs_data[c][5]    = bus.io_w_data_5;
      obs_data[c][6]    = bus.io_w_data_6;
      obs_data[c][7]    = bus.io_w_data_7;
      obs_req_ready[c]  = bus.io_req_ready;
      obs_beat_ready[c] = bus.io_beat_ready;
      obs_st_ready[c]   = bus.io_st_ready;
      obs_busy[c]       = bus.io_busy;
      obs_done[c]       = bus.io_done;
      obs_err[c]        = bus.io_err;
   endtask

   // Entered and left just after a rising edge; inputs change there and the
   // outputs are sampled on the falling edge.
   task automatic applyStimulus();
      int k = 0;
      for (int c = 0; c <= sc_len + 2; c++) begin
         bus.io_req_valid  = (c == 0);
         bus.io_req_set    = sc_set;
         bus.io_req_word   = sc_start;
         bus.io_beat_valid = beat_on[c];
         bus.io_beat_data  = beat_on[c] ? beats[k] : $urandom;
         bus.io_beat_last  = beat_on[c] ? last_bits[k] : 1'b0;
         bus.io_st_valid   = st_on[c];
         bus.io_st_set     = st_set_a[c];
         bus.io_st_word    = st_word_a[c];
         bus.io_st_data    = st_data_a[c];
         @(negedge clock);
         sample(c);
         if (beat_on[c]) k++;
         @(posedge clock);
         #1;
      end
      idle_inputs();
   endtask

   // Line-level model: each word holds the last store that hit the fill set
   // while filling, else the beat that the critical-word-first order sends
   // there; the line is written the cycle after the 8th beat.
   task automatic checkOutput();
      logic [31:0] line [8];
      logic [2:0]  d;
      logic        err_acc;
      logic        fill;
      logic        wr;
      int          k;
      err_acc = 1'b0;
      k = 0;
      for (int w = 0; w < 8; w++) begin
         d = 3'(w) - sc_start;
         line[w] = beats[d];
      end
      for (int c = 1; c <= sc_len; c++) begin
         if (st_on[c] && st_set_a[c] == sc_set) line[st_word_a[c]] = st_data_a[c];
      end
      for (int c = 0; c <= sc_len + 2; c++) begin
         exp_err[c] = err_acc;
         if (beat_on[c]) begin
            if (last_bits[k] != (k == 7)) err_acc = 1'b1;
            k++;
         end
         fill = (c >= 1) && (c <= sc_len);
         wr   = (c == sc_len + 1);
         exp_hs[c] = {(c == 0) || (c == sc_len + 2), fill, !wr, fill || wr, c == sc_len + 2};
         exp_w_en[c] = 1'b0;
         exp_addr[c] = '0;
         exp_mask[c] = '0;
         for (int i = 0; i < 8; i++) exp_data[c][i] = '0;
         if (wr) begin
            exp_w_en[c] = 1'b1;
            exp_addr[c] = sc_set;
            exp_mask[c] = 8'hFF;
            for (int i = 0; i < 8; i++) exp_data[c][i] = line[i];
         end else if (st_on[c] && !(fill && st_set_a[c] == sc_set)) begin
            exp_w_en[c] = 1'b1;
            exp_addr[c] = st_set_a[c];
            exp_mask[c] = 8'h01 << st_word_a[c];
            for (int i = 0; i < 8; i++) exp_data[c][i] = st_data_a[c];
         end
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b0;
      #1;
      total++;
      if ({bus.io_req_ready, bus.io_st_ready, bus.io_beat_ready, bus.io_busy,
           bus.io_done, bus.io_err} !== 6'b110000) begin
         bad++;
         $display("[TB] FAIL reset_flags: got %b want 110000", {bus.io_req_ready, bus.io_st_ready,
                  bus.io_beat_ready, bus.io_busy, bus.io_done, bus.io_err});
      end
      total++;
      if ({bus.io_w_en, bus.io_w_addr, bus.io_w_maskOH} !== 16'h0) begin
         bad++;
         $display("[TB] FAIL reset_wport: got %h want 0000", {bus.io_w_en, bus.io_w_addr, bus.io_w_maskOH});
      end
      total++;
      if ((bus.io_w_data_0 | bus.io_w_data_3 | bus.io_w_data_7) !== 32'h0) begin
         bad++;
         $display("[TB] FAIL reset_wdata: got %h want 0", bus.io_w_data_0 | bus.io_w_data_3 | bus.io_w_data_7);
      end
      @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      #1;
   endtask

   task automatic test_basic();
      int early = 0;
      dense_setup(7'h15, 3'd0);
      for (int j = 0; j < 8; j++) beats[j] = 32'hA0 + j;
      applyStimulus();
      for (int c = 0; c <= 8; c++) early += int'(obs_w_en[c]);
      total++;
      if (early != 0) begin bad++; $display("[TB] FAIL basic_early_write: got %0d writes want 0", early); end
      total++;
      if ({obs_w_en[9], obs_addr[9], obs_mask[9]} !== {1'b1, 7'h15, 8'hFF}) begin
         bad++;
         $display("[TB] FAIL basic_wport: got en=%b addr=%h mask=%h want en=1 addr=15 mask=ff",
                  obs_w_en[9], obs_addr[9], obs_mask[9]);
      end
      for (int i = 0; i < 8; i++) begin
         total++;
         if (obs_data[9][i] !== 32'hA0 + i) begin
            bad++;
            $display("[TB] FAIL basic_data%0d: got %h want %h", i, obs_data[9][i], 32'hA0 + i);
         end
      end
      total++;
      if ({obs_done[9], obs_done[10], obs_busy[9], obs_busy[10], obs_err[10]} !== 5'b01100) begin
         bad++;
         $display("[TB] FAIL basic_done_busy_err: got %b want 01100",
                  {obs_done[9], obs_done[10], obs_busy[9], obs_busy[10], obs_err[10]});
      end
   endtask

   task automatic test_wrap();
      dense_setup(7'h7F, 3'd6);
      for (int j = 0; j < 8; j++) beats[j] = 32'hB0 + j;
      applyStimulus();
      total++;
      if ({obs_w_en[9], obs_addr[9]} !== {1'b1, 7'h7F}) begin
         bad++;
         $display("[TB] FAIL wrap_addr: got en=%b addr=%h want en=1 addr=7f", obs_w_en[9], obs_addr[9]);
      end
      for (int i = 0; i < 8; i++) begin
         total++;
         if (obs_data[9][i] !== 32'hB0 + ((i + 2) % 8)) begin
            bad++;
            $display("[TB] FAIL wrap_data%0d: got %h want %h", i, obs_data[9][i], 32'hB0 + ((i + 2) % 8));
         end
      end
   endtask

   task automatic test_merge();
      logic [31:0] want3;
      for (int v = 0; v < 3; v++) begin
         dense_setup(7'h15, 3'd0);
         want3 = 32'hDEAD;
         if (v == 1) begin
            add_store(4, 7'h15, 3'd3, 32'hDEAD);
         end else begin
            add_store(2, 7'h15, 3'd3, 32'hDEAD);
         end
         if (v == 2) begin
            add_store(6, 7'h15, 3'd3, 32'hBEEF);
            want3 = 32'hBEEF;
         end
         applyStimulus();
         total++;
         if ((obs_w_en[2] | obs_w_en[4] | obs_w_en[6]) !== 1'b0) begin
            bad++;
            $display("[TB] FAIL merge%0d_passthru: got write during fill want none", v);
         end
         total++;
         if (obs_data[9][3] !== want3) begin
            bad++;
            $display("[TB] FAIL merge%0d_word3: got %h want %h", v, obs_data[9][3], want3);
         end
         for (int i = 0; i < 8; i++) begin
            if (i != 3) begin
               total++;
               if (obs_data[9][i] !== beats[i]) begin
                  bad++;
                  $display("[TB] FAIL merge%0d_data%0d: got %h want %h", v, i, obs_data[9][i], beats[i]);
               end
            end
         end
      end
   endtask

   task automatic test_store_stall();
      dense_setup(7'h15, 3'd0);
      add_store(3, 7'h02, 3'd5, 32'h1234);
      add_store(9, 7'h02, 3'd1, 32'h5555);
      add_store(10, 7'h02, 3'd1, 32'h5555);
      applyStimulus();
      total++;
      if ({obs_w_en[3], obs_addr[3], obs_mask[3], obs_data[3][0], obs_data[3][7]} !==
          {1'b1, 7'h02, 8'h20, 32'h1234, 32'h1234}) begin
         bad++;
         $display("[TB] FAIL store_pass: got en=%b addr=%h mask=%h d0=%h d7=%h want 1 02 20 1234 1234",
                  obs_w_en[3], obs_addr[3], obs_mask[3], obs_data[3][0], obs_data[3][7]);
      end
      total++;
      if ({obs_st_ready[9], obs_addr[9], obs_mask[9]} !== {1'b0, 7'h15, 8'hFF}) begin
         bad++;
         $display("[TB] FAIL store_stall: got rdy=%b addr=%h mask=%h want 0 15 ff",
                  obs_st_ready[9], obs_addr[9], obs_mask[9]);
      end
      total++;
      if ({obs_st_ready[10], obs_w_en[10], obs_addr[10], obs_mask[10], obs_data[10][4]} !==
          {1'b1, 1'b1, 7'h02, 8'h02, 32'h5555}) begin
         bad++;
         $display("[TB] FAIL store_after_stall: got rdy=%b en=%b addr=%h mask=%h d4=%h want 1 1 02 02 5555",
                  obs_st_ready[10], obs_w_en[10], obs_addr[10], obs_mask[10], obs_data[10][4]);
      end
      total++;
      if (obs_data[9][5] !== beats[5]) begin
         bad++;
         $display("[TB] FAIL store_other_set_line: got %h want %h", obs_data[9][5], beats[5]);
      end
   endtask

   task automatic test_err();
      dense_setup(7'h15, 3'd1);
      last_bits[3] = 1'b1;
      applyStimulus();
      total++;
      if ({obs_err[4], obs_err[5], obs_err[9], obs_err[10]} !== 4'b0111) begin
         bad++;
         $display("[TB] FAIL err_sticky: got %b want 0111", {obs_err[4], obs_err[5], obs_err[9], obs_err[10]});
      end
      total++;
      if ({obs_w_en[8], obs_w_en[9], obs_done[10]} !== 3'b011) begin
         bad++;
         $display("[TB] FAIL err_sequencing: got %b want 011", {obs_w_en[8], obs_w_en[9], obs_done[10]});
      end
      dense_setup(7'h16, 3'd0);
      applyStimulus();
      total++;
      if ({obs_err[0], obs_err[1], obs_err[10]} !== 3'b100) begin
         bad++;
         $display("[TB] FAIL err_clear: got %b want 100", {obs_err[0], obs_err[1], obs_err[10]});
      end
   endtask

   task automatic test_reset_mid_fill();
      int writes = 0;
      int busy_seen = 0;
      bus.io_req_valid = 1'b1;
      bus.io_req_set   = 7'h33;
      bus.io_req_word  = 3'd2;
      @(posedge clock);
      #1;
      bus.io_req_valid = 1'b0;
      for (int j = 0; j < 3; j++) begin
         bus.io_beat_valid = 1'b1;
         bus.io_beat_data  = $urandom;
         @(posedge clock);
         #1;
      end
      total++;
      if (bus.io_busy !== 1'b1) begin bad++; $display("[TB] FAIL abort_started: got busy=%b want 1", bus.io_busy); end
      #2;
      reset = 1'b0;
      #1;
      total++;
      if ({bus.io_busy, bus.io_beat_ready, bus.io_req_ready, bus.io_w_en} !== 4'b0010) begin
         bad++;
         $display("[TB] FAIL abort_async: got %b want 0010",
                  {bus.io_busy, bus.io_beat_ready, bus.io_req_ready, bus.io_w_en});
      end
      idle_inputs();
      @(posedge clock);
      @(posedge clock);
      #1;
      reset = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clock);
         writes += int'(bus.io_w_en);
         busy_seen += int'(bus.io_busy);
         @(posedge clock);
         #1;
      end
      total++;
      if (writes + busy_seen != 0) begin
         bad++;
         $display("[TB] FAIL abort_no_write: got %0d writes %0d busy want 0 0", writes, busy_seen);
      end
      dense_setup(7'h00, 3'd0);
      applyStimulus();
      writes = 0;
      for (int c = 0; c <= 10; c++) writes += int'(obs_w_en[c]);
      total++;
      if (writes != 1 || {obs_w_en[9], obs_addr[9], obs_mask[9]} !== {1'b1, 7'h00, 8'hFF}) begin
         bad++;
         $display("[TB] FAIL abort_new_line: got %0d writes en9=%b addr=%h mask=%h want 1 1 00 ff",
                  writes, obs_w_en[9], obs_addr[9], obs_mask[9]);
      end
      for (int i = 0; i < 8; i++) begin
         total++;
         if (obs_data[9][i] !== beats[i]) begin
            bad++;
            $display("[TB] FAIL abort_data%0d: got %h want %h", i, obs_data[9][i], beats[i]);
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 25; n++) begin
         int k = 0;
         int c = 1;
         clear_schedule();
         sc_set   = 7'($urandom);
         sc_start = 3'($urandom);
         for (int j = 0; j < 8; j++) begin
            if ($urandom_range(0, 9) == 0) last_bits[j] = !(j == 7);
         end
         while (k < 8) begin
            beat_on[c] = ($urandom_range(0, 2) != 0) || (c > 40);
            if (beat_on[c]) k++;
            c++;
         end
         sc_len = c - 1;
         for (int i = 0; i <= sc_len + 2; i++) begin
            if ($urandom_range(0, 2) == 0) begin
               add_store(i, ($urandom_range(0, 1) == 1) ? sc_set : 7'($urandom),
                         3'($urandom), $urandom);
            end
         end
         checkOutput();
         applyStimulus();
         for (int t = 0; t <= sc_len + 2; t++) begin
            total++;
            if ({obs_w_en[t], obs_addr[t], obs_mask[t]} !== {exp_w_en[t], exp_addr[t], exp_mask[t]}) begin
               bad++;
               $display("[TB] FAIL rnd%0d_c%0d_wport: got en=%b addr=%h mask=%h want en=%b addr=%h mask=%h",
                        n, t, obs_w_en[t], obs_addr[t], obs_mask[t], exp_w_en[t], exp_addr[t], exp_mask[t]);
            end
            for (int i = 0; i < 8; i++) begin
               total++;
               if (obs_data[t][i] !== exp_data[t][i]) begin
                  bad++;
                  $display("[TB] FAIL rnd%0d_c%0d_data%0d: got %h want %h", n, t, i,
                           obs_data[t][i], exp_data[t][i]);
               end
            end
            total++;
            if ({obs_req_ready[t], obs_beat_ready[t], obs_st_ready[t], obs_busy[t], obs_done[t]} !== exp_hs[t]) begin
               bad++;
               $display("[TB] FAIL rnd%0d_c%0d_handshake: got %b want %b", n, t,
                        {obs_req_ready[t], obs_beat_ready[t], obs_st_ready[t], obs_busy[t], obs_done[t]}, exp_hs[t]);
            end
            if (t >= 1) begin
               total++;
               if (obs_err[t] !== exp_err[t]) begin
                  bad++;
                  $display("[TB] FAIL rnd%0d_c%0d_err: got %b want %b", n, t, obs_err[t], exp_err[t]);
               end
            end
         end
      end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_basic();
      test_wrap();
      test_merge();
      test_store_stall();
      test_err();
      test_reset_mid_fill();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
